// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the streaming radix-2 FFT: two-bank ping-pong store
// written in bit-reversed order, drained in natural order behind a valid/ready register.
module fft_bitrev_reorder #(
  parameter int N          = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [0:1][DATA_WIDTH-1:0]   din,
  input  logic                                in_valid,
  output logic signed [0:1][DATA_WIDTH-1:0]   dout,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                overflow
);

  localparam int LOG2_N = $clog2(N);
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

  typedef logic [0:1][DATA_WIDTH-1:0] sample_t;

  sample_t             mem_q [2][N];

  logic [LOG2_N-1:0]   wr_idx_q, wr_idx_d;
  logic                wr_bank_q, wr_bank_d;
  logic                drop_q, drop_d;
  logic [LOG2_N-1:0]   rd_idx_q, rd_idx_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          full_q, full_d;
  sample_t             dout_q, dout_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                overflow_q, overflow_d;

  logic                drop_now;
  logic                store;
  logic                load;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
    logic [LOG2_N-1:0] r;
    for (int b = 0; b < LOG2_N; b++) begin
      r[b] = v[LOG2_N-1-b];
    end
    return r;
  endfunction

  // The drop decision is taken on the first sample of a frame and then held.
  assign drop_now = (wr_idx_q == '0) ? full_q[wr_bank_q] : drop_q;
  assign store    = in_valid && !drop_now;
  assign load     = (!out_valid_q || out_ready) && full_q[rd_bank_q];

  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    drop_d      = drop_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;

    if (load) begin
      dout_d      = mem_q[rd_bank_q][bitrev(rd_idx_q)];
      out_valid_d = 1'b1;
      out_last_d  = (rd_idx_q == LAST_IDX);
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + LOG2_N'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (in_valid) begin
      drop_d = drop_now;
      if (drop_now) begin
        overflow_d = 1'b1;
      end
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d = '0;
        if (!drop_now) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end else begin
        wr_idx_d = wr_idx_q + LOG2_N'(1);
      end
    end
  end

  // Sample storage carries no reset; its contents are meaningless until a bank is full.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_bank_q][wr_idx_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      drop_q      <= 1'b0;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      drop_q      <= drop_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: frames are reordered by a queue
// model (natural[n] = received[bitrev(n)]) and compared on every valid output cycle.
module tb_fft_bitrev_reorder;

  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int LOGN = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic signed [0:1][DW-1:0]   din;
  logic                        in_valid;
  logic signed [0:1][DW-1:0]   dout;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic                        overflow;

  int          checks    = 0;
  int          errors    = 0;
  int          cycle     = 0;
  int          readyMode = 1;
  bit          trackGaps = 0;
  bit          hsStarted = 0;
  int          gapCount  = 0;
  logic [2*DW:0] expQ[$];

  fft_bitrev_reorder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic int bitRev(input int v);
    int r = 0;
    for (int b = 0; b < LOGN; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Downstream ready: 0 = stalled, 1 = always ready, 2 = 1,0,0,1 pattern, 3 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       out_ready = 1'b0;
        2:       out_ready = !((cycle % 4 == 1) || (cycle % 4 == 2));
        3:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Every valid output cycle is compared with the head of the expected queue;
  // the head is retired only on a handshake, so stalls must hold the same value.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          checkOutput("dout", 64'({dout[0], dout[1]}), 64'(expQ[0][2*DW-1:0]));
          checkOutput("out_last", 64'(out_last), 64'(expQ[0][2*DW]));
          if (out_ready) begin
            void'(expQ.pop_front());
            hsStarted = 1'b1;
          end
        end
      end else if (trackGaps && hsStarted && expQ.size() > 0) begin
        gapCount++;
      end
    end
  end

  // gap < 0 selects a random 0..2 idle cycles before each sample.
  task automatic applyStimulus(input bit ramp, input int gap, input bit expectDrop);
    logic [2*DW-1:0] frm [N];
    int              idle;
    for (int i = 0; i < N; i++) begin
      idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int g = 0; g < idle; g++) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (ramp) begin
        din[0] = DW'(i);
        din[1] = DW'(-i);
      end else begin
        din[0] = DW'($urandom);
        din[1] = DW'($urandom);
      end
      frm[i]   = {din[0], din[1]};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!expectDrop) begin
      for (int n = 0; n < N; n++) begin
        expQ.push_back({(n == N - 1), frm[bitRev(n)]});
      end
    end
  endtask

  task automatic waitDrain(input int budget);
    int c = 0;
    while (expQ.size() > 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    checkOutput("drain", 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  task automatic waitRoom(input int budget);
    int c = 0;
    while (expQ.size() > N && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (expQ.size() > N) begin
      checkOutput("room_timeout", 64'(expQ.size()), 64'(N));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dout", 64'({dout[0], dout[1]}), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_last", 64'(out_last), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single ramp frame: output appears two edges after the last input.
    readyMode = 1;
    applyStimulus(1'b1, 0, 1'b0);
    @(negedge clk);
    checkOutput("t1_no_early_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("t1_valid_latency", 64'(out_valid), 64'd1);
    waitDrain(100);
    checkOutput("t1_ovf", 64'(overflow), 64'd0);

    // Four back-to-back frames must stream without bubbles.
    gapCount  = 0;
    hsStarted = 1'b0;
    trackGaps = 1'b1;
    for (int f = 0; f < 4; f++) applyStimulus(1'b0, 0, 1'b0);
    waitDrain(100);
    trackGaps = 1'b0;
    checkOutput("t2_gaps", 64'(gapCount), 64'd0);
    checkOutput("t2_ovf", 64'(overflow), 64'd0);

    // Patterned backpressure.
    readyMode = 2;
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    waitDrain(200);
    checkOutput("t3_ovf", 64'(overflow), 64'd0);

    // Fully stalled: third frame has no free bank and is dropped.
    readyMode = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("t4_ovf_set", 64'(overflow), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_valid_held", 64'(out_valid), 64'd1);
    readyMode = 1;
    waitDrain(100);
    applyStimulus(1'b0, 0, 1'b0);
    waitDrain(100);
    checkOutput("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Sparse input: one valid every three cycles.
    applyStimulus(1'b1, 2, 1'b0);
    applyStimulus(1'b0, 2, 1'b0);
    waitDrain(200);

    // Reset while one frame drains and the next is half written.
    applyStimulus(1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      din[0]   = DW'($urandom);
      din[1]   = DW'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t6_rst_dout", 64'({dout[0], dout[1]}), 64'd0);
    checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_last", 64'(out_last), 64'd0);
    checkOutput("t6_rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 0, 1'b0);
    waitDrain(100);
    checkOutput("t6_ovf", 64'(overflow), 64'd0);

    // Random data, random input gaps, random backpressure, paced so no drop can occur.
    readyMode = 3;
    for (int f = 0; f < 8; f++) begin
      waitRoom(400);
      applyStimulus(1'b0, -1, 1'b0);
    end
    waitDrain(400);
    checkOutput("rand_ovf", 64'(overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
